// File: rtl/multi_pwm_gen_pkg.sv
// pwm_pkg: shared types, default parameters and RPM->duty conversion for
// the multi-channel PWM generator (multi_pwm_gen).
package pwm_pkg;
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_RPM_W      = 16;
  localparam int DEF_PERIOD     = 100;
  localparam int DEF_RPM_OFFSET = 500;
  localparam int DEF_RPM_SHIFT  = 6;
  localparam int DEF_MAX_DUTY   = 90;
  localparam int DEF_SLEW_STEP  = 4;

  typedef logic [$clog2(DEF_PERIOD+1)-1:0] duty_t;
  typedef logic [DEF_RPM_W-1:0]            rpm_t;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} pwm_state_e;

  // Zero at or below the offset, otherwise shifted excess clamped to max_duty.
  // Operands are zero-extended RPM values, so the subtraction cannot wrap once
  // r > offset; the clamp happens before the caller narrows to duty width.
  function automatic logic [31:0] rpm_to_duty(input logic [31:0] r,
                                               input logic [31:0] offset,
                                               input int          shift,
                                               input logic [31:0] max_duty);
    logic [31:0] d;
    if (r <= offset) return '0;
    d = (r - offset) >> shift;
    return (d > max_duty) ? max_duty : d;
  endfunction
endpackage

// File: rtl/multi_pwm_gen_if.sv
// multi_pwm_gen_if: RPM-vector load handshake.
//   load_valid  master->slave  new vector offered
//   load_ready  slave->master  block can accept a vector
//   mot_rpm     master->slave  channel i at [i*RPM_W +: RPM_W]
interface multi_pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int RPM_W  = DEF_RPM_W
);
  logic                    load_valid;
  logic                    load_ready;
  logic [NUM_CH*RPM_W-1:0] mot_rpm;

  modport master (output load_valid, output mot_rpm, input  load_ready);
  modport slave  (input  load_valid, input  mot_rpm, output load_ready);
endinterface

// File: rtl/multi_pwm_gen_channel.sv
// pwm_channel: one PWM lane. Holds the active duty, updates it on the apply
// strobe and compares it against the shared period counter.
//   duty_pending in   target duty for this lane
//   apply        in   update strobe (period boundary or IDLE)
//   cnt, running in   shared counter / run state
//   mot_pwm      out  lane output
//   reach        out  target reachable by this apply (always 1 without slew)
// Optional: PWM_SLEW_LIMIT_EN limits each apply to +/-SLEW_STEP counts.
module pwm_channel #(
  parameter int PERIOD    = 100,
  parameter int DUTY_W    = $clog2(PERIOD+1),
  parameter int SLEW_STEP = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty_pending,
  input  logic              apply,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              running,
  output logic              mot_pwm,
  output logic              reach
);
  logic [DUTY_W-1:0] duty_active;
  logic [DUTY_W-1:0] duty_nxt;

`ifdef PWM_SLEW_LIMIT_EN
  localparam logic [DUTY_W-1:0] STEP = DUTY_W'(SLEW_STEP);

  // Differences instead of active+STEP so the compare cannot overflow.
  always_comb begin
    duty_nxt = duty_pending;
    reach    = 1'b1;
    if (duty_pending > duty_active) begin
      if (duty_pending - duty_active > STEP) begin
        duty_nxt = duty_active + STEP;
        reach    = 1'b0;
      end
    end else if (duty_active - duty_pending > STEP) begin
      duty_nxt = duty_active - STEP;
      reach    = 1'b0;
    end
  end
`else
  always_comb begin
    duty_nxt = duty_pending;
    reach    = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      duty_active <= '0;
    else if (apply) duty_active <= duty_nxt;
  end

  assign mot_pwm = running && (cnt < duty_active);
endmodule

// File: rtl/multi_pwm_gen.sv
// multi_pwm_gen: NUM_CH-channel motor PWM generator with one shared period
// counter. RPM vectors arrive over a valid/ready handshake, are converted to
// duty counts and held pending until the next period boundary (or at once in
// IDLE), so outputs never glitch mid-period.
//   clk, reset   clock, async active-high reset
//   enable       1 = run, 0 = stop after the current period
//   load         multi_pwm_gen_if.slave (load_valid/load_ready/mot_rpm)
//   mot_pwm      PWM outputs
//   period_start 1-cycle pulse at cnt==0 in RUN
//   running      FSM in RUN or STOPPING
// Optional: PWM_SLEW_LIMIT_EN (slew-limited duty updates, see pwm_channel).
module multi_pwm_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int RPM_W      = DEF_RPM_W,
  parameter int PERIOD     = DEF_PERIOD,
  parameter int RPM_OFFSET = DEF_RPM_OFFSET,
  parameter int RPM_SHIFT  = DEF_RPM_SHIFT,
  parameter int MAX_DUTY   = DEF_MAX_DUTY,
  parameter int SLEW_STEP  = DEF_SLEW_STEP
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  multi_pwm_gen_if.slave    load,
  output logic [NUM_CH-1:0] mot_pwm,
  output logic              period_start,
  output logic              running
);
  localparam int DUTY_W = $clog2(PERIOD+1);

  pwm_state_e                    state, state_nxt;
  logic [DUTY_W-1:0]             cnt;
  logic [NUM_CH-1:0][DUTY_W-1:0] duty_pending;
  logic [NUM_CH-1:0][DUTY_W-1:0] duty_conv;
  logic [NUM_CH-1:0]             reach;
  logic                          pend_v;
  logic                          boundary, accept, apply;

  assign running         = (state != IDLE);
  assign boundary        = running && (cnt == DUTY_W'(PERIOD-1));
  assign period_start    = (state == RUN) && (cnt == '0);
  assign load.load_ready = ~pend_v;
  assign accept          = load.load_valid && load.load_ready;
  // In IDLE nothing is on the pins, so a pending vector may land immediately.
  assign apply           = pend_v && ((state == IDLE) || boundary);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      duty_conv[i] = DUTY_W'(rpm_to_duty(32'(load.mot_rpm[i*RPM_W +: RPM_W]),
                                         32'(RPM_OFFSET), RPM_SHIFT,
                                         32'(MAX_DUTY)));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (enable) state_nxt = RUN;
      RUN:      if (!enable) state_nxt = STOPPING;
      STOPPING: if (enable) state_nxt = RUN;
                else if (boundary) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_pending <= '0;
      pend_v       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!running || boundary) cnt <= '0;
      else                      cnt <= cnt + DUTY_W'(1);
      if (accept) duty_pending <= duty_conv;
      // With slew limiting, pend_v holds until every lane has hit its target.
      if (accept)                pend_v <= 1'b1;
      else if (apply && &reach)  pend_v <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .PERIOD(PERIOD), .DUTY_W(DUTY_W), .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .clk(clk), .reset(reset),
      .duty_pending(duty_pending[g]), .apply(apply),
      .cnt(cnt), .running(running),
      .mot_pwm(mot_pwm[g]), .reach(reach[g])
    );
  end
endmodule
